// File: rtl/weight_stream_mem.sv
// Banked weight memory: loads NUM_NEURON x NUM_WEIGHT words in neuron-major
// order, then streams every weight index with all banks read in parallel
// behind a valid/ready handshake.
module weight_stream_mem #(
  parameter int NUM_WEIGHT = 30,
  parameter int NUM_NEURON = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load_start,
  input  logic                             ld_valid,
  input  logic [DATA_WIDTH-1:0]            ld_data,
  output logic                             ld_ready,
  output logic                             load_done,
  output logic                             loaded,
  input  logic                             rd_start,
  input  logic                             w_ready,
  output logic                             w_valid,
  output logic [NUM_NEURON*DATA_WIDTH-1:0] w_out,
  output logic [ADDR_WIDTH-1:0]            w_idx,
  output logic                             w_last,
  output logic                             busy
);

  // A one-entry dimension still needs a 1-bit counter.
  localparam int NRN_WIDTH = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_WT  = ADDR_WIDTH'(NUM_WEIGHT - 1);
  localparam logic [NRN_WIDTH-1:0]  LAST_NRN = NRN_WIDTH'(NUM_NEURON - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [NRN_WIDTH-1:0]  nrn_cnt_q, nrn_cnt_d;
  logic [ADDR_WIDTH-1:0] wt_cnt_q, wt_cnt_d;
  logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic                  rd_all_q, rd_all_d;   // every index has been read
  logic                  loaded_q, loaded_d;
  logic                  load_done_q, load_done_d;
  logic                  w_valid_q, w_valid_d;
  logic [ADDR_WIDTH-1:0] w_idx_q, w_idx_d;
  logic                  w_last_q, w_last_d;
  logic                  wr_en;
  logic                  rd_en;
  logic                  advance;

  // Per-bank read registers; these are the w_out flops themselves.
  logic [DATA_WIDTH-1:0] w_out_q [NUM_NEURON];

  // Next-state, counter and handshake logic.
  always_comb begin
    state_d     = state_q;
    nrn_cnt_d   = nrn_cnt_q;
    wt_cnt_d    = wt_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    rd_all_d    = rd_all_q;
    loaded_d    = loaded_q;
    load_done_d = 1'b0;
    w_valid_d   = w_valid_q;
    w_idx_d     = w_idx_q;
    w_last_d    = w_last_q;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    advance     = !w_valid_q || w_ready;

    case (state_q)
      S_IDLE: begin
        // load_start has priority; a coincident rd_start is dropped.
        if (load_start) begin
          state_d   = S_LOAD;
          loaded_d  = 1'b0;
          nrn_cnt_d = '0;
          wt_cnt_d  = '0;
        end else if (rd_start && loaded_q) begin
          state_d  = S_STREAM;
          rd_cnt_d = '0;
          rd_all_d = 1'b0;
        end
      end

      S_LOAD: begin
        if (ld_valid) begin
          wr_en = 1'b1;
          if (wt_cnt_q == LAST_WT) begin
            wt_cnt_d = '0;
            if (nrn_cnt_q == LAST_NRN) begin
              nrn_cnt_d   = '0;
              state_d     = S_IDLE;
              loaded_d    = 1'b1;
              load_done_d = 1'b1;
            end else begin
              nrn_cnt_d = nrn_cnt_q + NRN_WIDTH'(1);
            end
          end else begin
            wt_cnt_d = wt_cnt_q + ADDR_WIDTH'(1);
          end
        end
      end

      S_STREAM: begin
        if (advance) begin
          if (!rd_all_q) begin
            rd_en     = 1'b1;
            w_valid_d = 1'b1;
            w_idx_d   = rd_cnt_q;
            w_last_d  = (rd_cnt_q == LAST_WT);
            if (rd_cnt_q == LAST_WT) begin
              rd_all_d = 1'b1;
            end else begin
              rd_cnt_d = rd_cnt_q + ADDR_WIDTH'(1);
            end
          end else begin
            // Only reachable once the w_last beat has been accepted.
            w_valid_d = 1'b0;
            state_d   = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      nrn_cnt_q   <= '0;
      wt_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      rd_all_q    <= 1'b0;
      loaded_q    <= 1'b0;
      load_done_q <= 1'b0;
      w_valid_q   <= 1'b0;
      w_idx_q     <= '0;
      w_last_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      nrn_cnt_q   <= nrn_cnt_d;
      wt_cnt_q    <= wt_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_all_q    <= rd_all_d;
      loaded_q    <= loaded_d;
      load_done_q <= load_done_d;
      w_valid_q   <= w_valid_d;
      w_idx_q     <= w_idx_d;
      w_last_q    <= w_last_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_NEURON; gi++) begin : g_bank
      logic [DATA_WIDTH-1:0] mem [NUM_WEIGHT];

      // Bank write port; contents survive reset.
      always_ff @(posedge clk) begin
        if (wr_en && (nrn_cnt_q == NRN_WIDTH'(gi))) begin
          mem[wt_cnt_q] <= ld_data;
        end
      end

      // Registered bank read; holds while the consumer stalls.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          w_out_q[gi] <= '0;
        end else if (rd_en) begin
          w_out_q[gi] <= mem[rd_cnt_q];
        end
      end

      assign w_out[gi*DATA_WIDTH +: DATA_WIDTH] = w_out_q[gi];
    end
  endgenerate

  assign ld_ready  = (state_q == S_LOAD);
  assign load_done = load_done_q;
  assign loaded    = loaded_q;
  assign w_valid   = w_valid_q;
  assign w_idx     = w_idx_q;
  assign w_last    = w_last_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_weight_stream_mem.sv
// Self-checking bench for weight_stream_mem: default build plus a
// one-weight, one-neuron build sharing clock and reset.
module tb_weight_stream_mem;

  localparam int NW = 30;
  localparam int NN = 4;
  localparam int DW = 16;
  localparam int AW = $clog2(NW);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default-build signals
  logic             load_start = 1'b0, ld_valid = 1'b0, rd_start = 1'b0, w_ready = 1'b0;
  logic [DW-1:0]    ld_data = '0;
  logic             ld_ready, load_done, loaded, w_valid, w_last, busy;
  logic [NN*DW-1:0] w_out;
  logic [AW-1:0]    w_idx;

  // Single-weight build signals
  logic             s_load_start = 1'b0, s_ld_valid = 1'b0, s_rd_start = 1'b0, s_w_ready = 1'b0;
  logic [DW-1:0]    s_ld_data = '0;
  logic             s_ld_ready, s_load_done, s_loaded, s_w_valid, s_w_last, s_busy;
  logic [DW-1:0]    s_w_out;
  logic [0:0]       s_w_idx;

  weight_stream_mem #(.NUM_WEIGHT(NW), .NUM_NEURON(NN), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready(ld_ready), .load_done(load_done), .loaded(loaded),
    .rd_start(rd_start), .w_ready(w_ready), .w_valid(w_valid), .w_out(w_out),
    .w_idx(w_idx), .w_last(w_last), .busy(busy)
  );

  weight_stream_mem #(.NUM_WEIGHT(1), .NUM_NEURON(1), .DATA_WIDTH(DW)) dut_s (
    .clk(clk), .rst_n(rst_n), .load_start(s_load_start), .ld_valid(s_ld_valid),
    .ld_data(s_ld_data), .ld_ready(s_ld_ready), .load_done(s_load_done), .loaded(s_loaded),
    .rd_start(s_rd_start), .w_ready(s_w_ready), .w_valid(s_w_valid), .w_out(s_w_out),
    .w_idx(s_w_idx), .w_last(s_w_last), .busy(s_busy)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [NN][NW];

  typedef struct packed {
    logic [31:0]      idx;
    logic [NN*DW-1:0] data;
    logic             last;
  } beat_t;
  beat_t exp_q[$];

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (w_valid !== 1'b0 || w_out !== '0 || w_idx !== '0 || w_last !== 1'b0 ||
        ld_ready !== 1'b0 || load_done !== 1'b0 || loaded !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got valid=%0b out=%h idx=%0d last=%0b rdy=%0b done=%0b loaded=%0b busy=%0b required all zero",
               w_valid, w_out, w_idx, w_last, ld_ready, load_done, loaded, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || loaded !== 1'b0 || s_busy !== 1'b0 || s_loaded !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got busy=%0b loaded=%0b s_busy=%0b s_loaded=%0b required 0",
               busy, loaded, s_busy, s_loaded);
    end
    $display("reset: done");
  endtask

  // rd_start with nothing loaded must not start a stream.
  task automatic test_rd_unloaded();
    @(negedge clk); rd_start = 1'b1; w_ready = 1'b1;
    @(negedge clk); rd_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (busy !== 1'b0 || w_valid !== 1'b0) begin
        errors++;
        $display("FAIL rd_unloaded cycle %0d got busy=%0b w_valid=%0b required 0/0", c, busy, w_valid);
      end
      @(negedge clk);
    end
    $display("rd_unloaded: rd_start ignored");
  endtask

  // Load NN*NW words (value k ^ mask); optional rd_start alongside load_start,
  // and a load_start/rd_start pulse mid-load that must be ignored.
  task automatic load_image(input bit toggle, input logic [DW-1:0] mask, input bit with_rd);
    int k = 0;
    int cyc = 0;
    @(negedge clk); load_start = 1'b1; rd_start = with_rd;
    @(negedge clk); load_start = 1'b0; rd_start = 1'b0;
    checks++;
    if (busy !== 1'b1 || ld_ready !== 1'b1 || w_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_enter got busy=%0b ld_ready=%0b w_valid=%0b required 1/1/0", busy, ld_ready, w_valid);
    end
    while (k < NN*NW && cyc < 1000) begin
      checks++;
      if (ld_ready !== 1'b1 || load_done !== 1'b0 || loaded !== 1'b0 || w_valid !== 1'b0) begin
        errors++;
        $display("FAIL load_cycle word %0d got ld_ready=%0b load_done=%0b loaded=%0b w_valid=%0b required 1/0/0/0",
                 k, ld_ready, load_done, loaded, w_valid);
      end
      load_start = (cyc == 60);
      rd_start   = (cyc == 60);
      if (!toggle || (cyc % 2 == 0)) begin
        ld_valid = 1'b1;
        ld_data  = DW'(k) ^ mask;
        model[k / NW][k % NW] = DW'(k) ^ mask;
        k++;
      end else begin
        ld_valid = 1'b0;
        ld_data  = 16'hDEAD;
      end
      cyc++;
      @(negedge clk);
    end
    ld_valid = 1'b0; ld_data = '0; load_start = 1'b0; rd_start = 1'b0;
    checks++;
    if (load_done !== 1'b1 || loaded !== 1'b1 || busy !== 1'b0 || ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_done_pulse got done=%0b loaded=%0b busy=%0b ld_ready=%0b required 1/1/0/0",
               load_done, loaded, busy, ld_ready);
    end
    @(negedge clk);
    checks++;
    if (load_done !== 1'b0 || loaded !== 1'b1) begin
      errors++;
      $display("FAIL load_done_single got done=%0b loaded=%0b required 0/1", load_done, loaded);
    end
    $display("load: %0d words in %0d cycles toggle=%0b mask=%h", k, cyc, toggle, mask);
  endtask

  // Stream all indices; stall mode holds w_ready low 3 cycles on beats 0, 5, 29.
  task automatic stream_check(input bit stall);
    int beats = 0;
    int cyc = 0;
    int stall_left = 0;
    bit held_v = 1'b0;
    logic [NN*DW-1:0] held_out = '0;
    logic [AW-1:0]    held_idx = '0;
    logic             held_last = 1'b0;
    beat_t e;
    exp_q.delete();
    for (int i = 0; i < NW; i++) begin
      logic [NN*DW-1:0] d;
      for (int n = 0; n < NN; n++) d[n*DW +: DW] = model[n][i];
      exp_q.push_back({32'(i), d, (i == NW - 1)});
    end
    @(negedge clk); rd_start = 1'b1; w_ready = 1'b1;
    @(negedge clk); rd_start = 1'b0;
    checks++;
    if (w_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stream_enter got w_valid=%0b busy=%0b required 0/1", w_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (w_valid !== 1'b1 || w_idx !== '0) begin
      errors++;
      $display("FAIL first_beat_latency got w_valid=%0b w_idx=%0d required 1/0", w_valid, w_idx);
    end
    while (beats < NW && cyc < 500) begin
      if (w_valid === 1'b1) begin
        if (held_v) begin
          checks++;
          if (w_out !== held_out || w_idx !== held_idx || w_last !== held_last) begin
            errors++;
            $display("FAIL stall_hold got idx=%0d last=%0b out=%h required idx=%0d last=%0b out=%h",
                     w_idx, w_last, w_out, held_idx, held_last, held_out);
          end
        end else begin
          stall_left = (stall && (w_idx == 0 || w_idx == 5 || w_idx == 29)) ? 3 : 0;
        end
        if (stall_left > 0) begin
          w_ready = 1'b0;
          stall_left--;
          held_v = 1'b1; held_out = w_out; held_idx = w_idx; held_last = w_last;
        end else begin
          w_ready = 1'b1;
          held_v = 1'b0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_beat got idx=%0d required no beat", w_idx);
          end else begin
            e = exp_q.pop_front();
            if (32'(w_idx) !== e.idx || w_out !== e.data || w_last !== e.last) begin
              errors++;
              $display("FAIL beat got idx=%0d last=%0b out=%h required idx=%0d last=%0b out=%h",
                       w_idx, w_last, w_out, e.idx, e.last, e.data);
            end
          end
          $display("beat: idx=%0d last=%0b out=%h", w_idx, w_last, w_out);
          beats++;
        end
      end else begin
        w_ready = 1'b1;
        checks++;
        if (beats > 0) begin
          errors++;
          $display("FAIL gap after beat %0d got w_valid=0 required 1", beats);
        end
      end
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc >= 500 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_count got %0d beats required %0d", beats, NW);
    end
    checks++;
    if (w_valid !== 1'b0 || busy !== 1'b0 || loaded !== 1'b1) begin
      errors++;
      $display("FAIL stream_end got w_valid=%0b busy=%0b loaded=%0b required 0/0/1", w_valid, busy, loaded);
    end
  endtask

  // ld_valid while IDLE must not be accepted or written.
  task automatic test_idle_write();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      ld_valid = 1'b1; ld_data = 16'hBEEF;
      checks++;
      if (ld_ready !== 1'b0) begin
        errors++;
        $display("FAIL idle_ld_ready got %0b required 0", ld_ready);
      end
    end
    @(negedge clk); ld_valid = 1'b0; ld_data = '0;
    $display("idle_write: ld_valid driven while idle");
  endtask

  task automatic test_reset_mid_stream();
    int cyc = 0;
    @(negedge clk); rd_start = 1'b1; w_ready = 1'b1;
    @(negedge clk); rd_start = 1'b0;
    while (!(w_valid === 1'b1 && w_idx == AW'(10)) && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc >= 100) begin
      errors++;
      $display("FAIL reach_beat10 got timeout required beat 10");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (w_valid !== 1'b0 || loaded !== 1'b0 || busy !== 1'b0 || w_out !== '0 || w_idx !== '0) begin
      errors++;
      $display("FAIL async_reset got w_valid=%0b loaded=%0b busy=%0b out=%h idx=%0d required zeros",
               w_valid, loaded, busy, w_out, w_idx);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); rd_start = 1'b1;
    @(negedge clk); rd_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (busy !== 1'b0 || w_valid !== 1'b0) begin
        errors++;
        $display("FAIL rd_after_reset got busy=%0b w_valid=%0b required 0/0", busy, w_valid);
      end
      @(negedge clk);
    end
    $display("reset_mid_stream: aborted at beat 10");
  endtask

  task automatic test_single();
    beat_t e;
    @(negedge clk); s_load_start = 1'b1;
    @(negedge clk); s_load_start = 1'b0;
    checks++;
    if (s_ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ld_ready got %0b required 1", s_ld_ready);
    end
    s_ld_valid = 1'b1; s_ld_data = 16'h1234;
    exp_q.delete();
    exp_q.push_back({32'd0, {(NN-1)*DW{1'b0}}, 16'h1234, 1'b1});
    @(negedge clk); s_ld_valid = 1'b0; s_ld_data = '0;
    checks++;
    if (s_load_done !== 1'b1 || s_loaded !== 1'b1 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_load_done got done=%0b loaded=%0b busy=%0b required 1/1/0", s_load_done, s_loaded, s_busy);
    end
    @(negedge clk); s_rd_start = 1'b1; s_w_ready = 1'b1;
    @(negedge clk); s_rd_start = 1'b0;
    @(negedge clk);
    checks++;
    e = exp_q.pop_front();
    if (s_w_valid !== 1'b1 || 32'(s_w_idx) !== e.idx || s_w_last !== e.last || {{(NN-1)*DW{1'b0}}, s_w_out} !== e.data) begin
      errors++;
      $display("FAIL single_beat got valid=%0b idx=%0d last=%0b out=%h required 1/%0d/%0b/%h",
               s_w_valid, s_w_idx, s_w_last, s_w_out, e.idx, e.last, e.data[DW-1:0]);
    end
    $display("single: beat idx=%0d last=%0b out=%h", s_w_idx, s_w_last, s_w_out);
    @(negedge clk);
    checks++;
    if (s_w_valid !== 1'b0 || s_busy !== 1'b0 || s_loaded !== 1'b1) begin
      errors++;
      $display("FAIL single_end got valid=%0b busy=%0b loaded=%0b required 0/0/1", s_w_valid, s_busy, s_loaded);
    end
  endtask

  initial begin
    test_reset();
    test_rd_unloaded();
    load_image(1'b0, 16'h0000, 1'b1);
    stream_check(1'b0);
    load_image(1'b1, 16'hFFFF, 1'b0);
    stream_check(1'b0);
    load_image(1'b1, 16'h0000, 1'b0);
    test_idle_write();
    stream_check(1'b1);
    test_reset_mid_stream();
    test_single();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_stream_mem.md
WEIGHT_STREAM_MEM -- requirements
Module: weight_stream_mem

Interface
REQ-001 SHALL provide parameter NUM_WEIGHT, default 30, weights per neuron (depth).
REQ-002 SHALL provide parameter NUM_NEURON, default 4, neurons (banks) read in parallel.
REQ-003 SHALL provide parameter DATA_WIDTH, default 16, two's-complement weight width.
REQ-004 SHALL provide parameter ADDR_WIDTH, default $clog2(NUM_WEIGHT), weight index width.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 load_start  input  1  one-cycle pulse; begins a load session.
REQ-008 ld_valid  input  1  load word present.
REQ-009 ld_data  input  DATA_WIDTH  load word.
REQ-010 ld_ready  output  1  module accepts a load word this cycle.
REQ-011 load_done  output  1  one-cycle pulse after the final load word.
REQ-012 loaded  output  1  memory holds a complete weight set.
REQ-013 rd_start  input  1  one-cycle pulse; begins a stream of all weight indices.
REQ-014 w_ready  input  1  consumer accepts the w_out beat.
REQ-015 w_valid  output  1  w_out/w_idx/w_last valid.
REQ-016 w_out  output  NUM_NEURON*DATA_WIDTH  weights of index w_idx; neuron n in bits [n*DATA_WIDTH +: DATA_WIDTH].
REQ-017 w_idx  output  ADDR_WIDTH  weight index of current beat.
REQ-018 w_last  output  1  current beat is index NUM_WEIGHT-1.
REQ-019 busy  output  1  state is not IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD, STREAM.
REQ-021 IDLE: load_start -> LOAD; else rd_start with loaded=1 -> STREAM; rd_start with loaded=0 ignored.
REQ-022 IDLE: load_start and rd_start in the same cycle -> LOAD; rd_start is discarded.
REQ-023 Entering LOAD SHALL clear loaded and zero neuron counter (nrn_cnt) and weight counter (wt_cnt).
REQ-024 LOAD: ld_ready=1; ld_valid=1 writes ld_data to bank nrn_cnt, address wt_cnt (neuron-major order: word k -> neuron k/NUM_WEIGHT, weight k%NUM_WEIGHT).
REQ-025 wt_cnt wraps NUM_WEIGHT-1 -> 0 and increments nrn_cnt; no writes occur when ld_valid=0.
REQ-026 Accepting word NUM_NEURON*NUM_WEIGHT-1 SHALL move to IDLE, set loaded=1 and pulse load_done for exactly one cycle, the cycle after that word is accepted.
REQ-027 ld_ready SHALL be 0 outside LOAD; ld_valid outside LOAD SHALL not write.
REQ-028 load_start/rd_start SHALL be ignored in LOAD and STREAM.
REQ-029 STREAM: define advance = !w_valid || w_ready; when advance and indices remain, all banks SHALL be read synchronously at the read counter and w_out/w_idx/w_last registered on the next edge.
REQ-030 First beat (index 0) SHALL have w_valid=1 two cycles after the cycle rd_start is sampled.
REQ-031 With w_ready held 1, one beat per cycle SHALL be delivered: indices 0..NUM_WEIGHT-1, no gaps.
REQ-032 While w_valid=1 and w_ready=0, w_out, w_idx, w_last SHALL hold stable.
REQ-033 Acceptance of the w_last beat SHALL drop w_valid next cycle and return to IDLE; loaded stays 1.
REQ-034 Memory reads SHALL return the last written value; no read-during-write case exists (modes exclusive).
REQ-035 NUM_WEIGHT=1 SHALL work: single beat with w_last=1.

Reset
REQ-036 rst_n=0 SHALL immediately force IDLE, counters 0, w_valid=0, w_out=0, w_idx=0, w_last=0, ld_ready=0, load_done=0, loaded=0, busy=0.
REQ-037 Memory contents SHALL not be reset; reset mid-LOAD or mid-STREAM aborts the session and requires a full reload.

Verification
REQ-038 Defaults; load 120 words value k (k=0..119) with ld_valid always 1 -> ld_ready 1 for 120 cycles, load_done single pulse, loaded=1; stream with w_ready=1 -> beat i has neuron n = n*30+i, w_last only at i=29.
REQ-039 Load with ld_valid toggling every other cycle -> exactly 120 writes, same memory image as REQ-038.
REQ-040 Stream with w_ready low on beats 0, 5, 29 for 3 cycles each -> outputs stable while stalled, 30 beats total, no duplicates or drops.
REQ-041 rd_start with loaded=0 -> busy stays 0, w_valid stays 0; load_start and rd_start together -> LOAD only.
REQ-042 rst_n low at beat 10 of stream -> w_valid=0 and loaded=0 same cycle; subsequent rd_start ignored until reload.
REQ-043 NUM_WEIGHT=1, NUM_NEURON=1 build -> load 1 word, one beat with w_idx=0, w_last=1.
